atm_timer_scheduler: RTL and testbench
======================================

Name: atm_timer_scheduler

Overview:
- Shares the single 100 Hz tick from the slow-clock divider among NUM_CH independent countdown timers used by the ATM control logic (PIN-entry timeout, card-eject timeout, message display hold, lockout).
- Requesters start or cancel a channel over one command port.
- On every tick, an FSM sweeps all channels through one shared decrementer and pulses the expiry output of any channel that reaches zero.

Parameters:
- NUM_CH, 4, number of timer channels (2..16).
- CNT_W, 16, width of tick count per channel (max 655.35 s at 100 Hz).
- CH_W, 2, channel index width; must equal ceil(log2(NUM_CH)).

Ports:
- clk_in  in  1  100 MHz board clock
- reset  in  1  synchronous, active-high reset
- tick_in  in  1  one-cycle pulse from the 100 Hz slow-clock divider
- req_valid  in  1  command present
- req_cmd  in  1  0 = START, 1 = CANCEL
- req_ch  in  CH_W  target channel
- req_ticks  in  CNT_W  START duration in ticks; ignored for CANCEL
- req_ready  out  1  command accepted when req_valid && req_ready
- active  out  NUM_CH  channel i counting
- expired  out  NUM_CH  one-cycle pulse when channel i times out
- busy  out  1  high while SWEEP in progress
- overrun  out  1  sticky tick-overrun flag (see Optional Feature)

Behaviour:
- Clocking and reset: single clock clk_in; reset synchronous active-high. On reset:
  - state = IDLE; all counters = 0; active = 0; expired = 0; busy = 0; tick_pending = 0; overrun = 0.
  - req_ready = 1 in the first cycle after reset deasserts.
- States: IDLE, SWEEP.
- req_ready = (state == IDLE) && !tick_in && !tick_pending. A tick always has priority over a command in the same cycle; the requester holds req_valid until ready.
- START accepted at cycle C, channel ch:
  - req_ticks > 0: cnt[ch] = req_ticks, active[ch] = 1 at C+1. Restarting an active channel reloads it with no expiry pulse.
  - req_ticks == 0: active[ch] stays 0; expired[ch] pulses at C+1.
- CANCEL accepted at C: active[ch] = 0 and cnt[ch] = 0 at C+1; no expiry pulse. CANCEL on an inactive channel is a no-op.
- Tick handling:
  - tick_in in IDLE at cycle T: enter SWEEP at T+1; idx = 0; busy = 1.
  - tick_in in SWEEP: set tick_pending. At SWEEP end, go directly to a new SWEEP with tick_pending cleared, and busy stays high.
- SWEEP: one channel per cycle. Channel k is processed in cycle T+1+k:
  - active and cnt > 1: cnt decrements.
  - active and cnt == 1: cnt = 0, active[k] = 0, expired[k] pulses at T+2+k.
  - inactive: untouched.
- After idx == NUM_CH-1, return to IDLE (busy = 0 at T+1+NUM_CH) unless tick_pending is set.
- Timing consequences:
  - Sweep length is NUM_CH cycles, so there is no overlap at 100 Hz. Back-to-back ticks are handled only through the pending flag.
  - Resolution is ±1 tick: a START of N expires after N-1 to N tick periods, depending on phase.
- expired pulses for several channels may coincide only when the pulses come from separate zero-length STARTs; they never coincide within one sweep.
- Reset mid-SWEEP: all state is cleared in the next cycle, and no expiry pulses are issued.

Optional Feature:
- Macro: ATM_TIMER_OVERRUN_EN.
- Defined: overrun is set when tick_in arrives while tick_pending is already 1, or when tick_in arrives in the last SWEEP cycle with tick_pending already 1. Once set, overrun stays high until reset. The extra tick is dropped.
- Undefined: overrun is tied to 0, and the extra tick is silently dropped. Core behaviour is otherwise identical.

Decomposition:
- Shared package atm_timer_pkg:
  - CMD_START / CMD_CANCEL constants.
  - State encoding for IDLE / SWEEP.
  - Default NUM_CH / CNT_W.
- Natural sub-module: atm_timer_slots, holding the NUM_CH × CNT_W counter array with active bits. It provides one read/decrement port used by SWEEP and one write port used by commands. The FSM, pending flag and expiry pulse generation stay in the top module.

Test Plan:
- Reset, then START ch0 with 3 ticks, then tick_in every 50 cycles -> active[0] = 1; expired[0] pulses exactly once, at (third tick cycle) + 2; active[0] = 0 afterwards.
- START ch2 with 0 ticks -> expired[2] pulses one cycle after acceptance; active[2] never rises.
- START ch1 with 5, two ticks, then CANCEL ch1 -> cnt[1] = 0, active[1] = 0; no expiry pulse after 10 further ticks.
- Simultaneous: tick_in and req_valid in the same IDLE cycle -> req_ready = 0 that cycle; command accepted at T+1+NUM_CH; sweep order ch0..ch3 verified through busy duration = 4 cycles.
- Two ticks 2 cycles apart, with all 4 channels at 2 ticks -> busy high for 8 consecutive cycles; all four expired pulses appear in cycles T+6..T+9 of the second sweep. With ATM_TIMER_OVERRUN_EN, a third tick inside that window sets overrun = 1.
- Assert reset during SWEEP with ch3 at cnt = 1 -> no expired[3] pulse; active = 0, busy = 0 the next cycle.

Source files
------------

// File: rtl/atm_timer_pkg.sv
// Shared definitions for the ATM countdown-timer scheduler.
//   - Command encodings for the request port (START / CANCEL).
//   - Sweep FSM state encoding.
//   - Default channel count and counter width.
package atm_timer_pkg;

  localparam int unsigned DefNumCh = 4;
  localparam int unsigned DefCntW  = 16;

  localparam logic CmdStart  = 1'b0;
  localparam logic CmdCancel = 1'b1;

  typedef enum logic {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } state_e;

endpackage

// File: rtl/atm_timer_slots.sv
// Counter storage for the timer scheduler: NUM_CH counters of CNT_W bits, each with an
// active bit.
// Ports:
//   clk_in, reset            clock, synchronous active-high reset
//   rd_idx, rd_cnt,          read/decrement port used by the sweep: rd_cnt/rd_active
//   rd_active, dec_en        show slot rd_idx; dec_en steps that slot down by one tick,
//                            clearing it (and its active bit) when it reaches zero
//   wr_en, wr_ch, wr_cnt,    command write port: loads count and active bit of slot wr_ch
//   wr_active
//   active                   active bit of every slot
module atm_timer_slots
  import atm_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [CH_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              rd_active,
  input  logic              dec_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_cnt,
  input  logic              wr_active,
  output logic [NUM_CH-1:0] active
);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] active_q;

  assign rd_cnt    = cnt_q[rd_idx];
  assign rd_active = active_q[rd_idx];
  assign active    = active_q;

  // Writes and decrements never coincide (commands are only taken while idle), but the
  // write port wins if they ever did.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
      active_q <= '0;
    end else if (wr_en) begin
      cnt_q[wr_ch]    <= wr_cnt;
      active_q[wr_ch] <= wr_active;
    end else if (dec_en && active_q[rd_idx]) begin
      if (cnt_q[rd_idx] > CNT_W'(1)) begin
        cnt_q[rd_idx] <= cnt_q[rd_idx] - CNT_W'(1);
      end else begin
        cnt_q[rd_idx]    <= '0;
        active_q[rd_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/atm_timer_scheduler.sv
// Shares the 100 Hz tick among NUM_CH countdown timers. Each tick launches a sweep that
// visits one channel per cycle through a single decrementer; a channel reaching zero
// pulses its expired bit. Commands (START / CANCEL) are accepted only while idle.
// Ports:
//   clk_in, reset       clock, synchronous active-high reset
//   tick_in             one-cycle 100 Hz tick pulse
//   req_valid/req_ready command handshake; req_cmd 0 = START, 1 = CANCEL
//   req_ch, req_ticks   target channel and START duration in ticks
//   active              per-channel counting flag
//   expired             per-channel one-cycle expiry pulse
//   busy                high while a sweep runs
//   overrun             sticky dropped-tick flag; only live when ATM_TIMER_OVERRUN_EN is
//                       defined, otherwise tied low
module atm_timer_scheduler
  import atm_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              req_valid,
  input  logic              req_cmd,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [CNT_W-1:0]  req_ticks,
  output logic              req_ready,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] expired,
  output logic              busy,
  output logic              overrun
);

  localparam logic [CH_W-1:0] LastIdx = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [NUM_CH-1:0] expired_q, expired_d;
  logic              extra_tick;

  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_active;
  logic              dec_en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_cnt;
  logic              wr_active;

  atm_timer_slots #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) u_slots (
    .clk_in    (clk_in),
    .reset     (reset),
    .rd_idx    (idx_q),
    .rd_cnt    (rd_cnt),
    .rd_active (rd_active),
    .dec_en    (dec_en),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_cnt    (wr_cnt),
    .wr_active (wr_active),
    .active    (active)
  );

  assign busy      = (state_q == StSweep);
  // A tick in the same cycle always beats a command.
  assign req_ready = (state_q == StIdle) && !tick_in && !pend_q;
  assign expired   = expired_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    expired_d  = '0;
    extra_tick = 1'b0;
    dec_en     = 1'b0;
    wr_en      = 1'b0;
    wr_ch      = req_ch;
    wr_cnt     = '0;
    wr_active  = 1'b0;

    case (state_q)
      StIdle: begin
        idx_d = '0;
        if (tick_in) begin
          state_d = StSweep;
        end else if (req_valid && req_ready) begin
          // CANCEL and zero-length START both leave the slot cleared.
          wr_en = 1'b1;
          if (req_cmd == CmdStart) begin
            if (req_ticks != '0) begin
              wr_cnt    = req_ticks;
              wr_active = 1'b1;
            end else begin
              expired_d[req_ch] = 1'b1;
            end
          end
        end
      end

      StSweep: begin
        dec_en = 1'b1;
        if (rd_active && (rd_cnt <= CNT_W'(1))) begin
          expired_d[idx_q] = 1'b1;
        end
        if (idx_q == LastIdx) begin
          idx_d = '0;
          // A tick landing in the last cycle is captured as if it had been pending.
          if (pend_q || tick_in) begin
            pend_d     = 1'b0;
            extra_tick = pend_q && tick_in;
          end else begin
            state_d = StIdle;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          if (tick_in) begin
            if (pend_q) begin
              extra_tick = 1'b1;
            end else begin
              pend_d = 1'b1;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      expired_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      expired_q <= expired_d;
    end
  end

`ifdef ATM_TIMER_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (extra_tick) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  // Extra ticks are dropped silently.
  logic unused_extra_tick;
  assign unused_extra_tick = extra_tick;
  assign overrun           = 1'b0;
`endif

endmodule

// File: tb/tb_atm_timer_scheduler.sv
module tb_atm_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tick_in = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_cmd = 1'b0;
  logic [CH_W-1:0]   req_ch = '0;
  logic [CNT_W-1:0]  req_ticks = '0;
  logic              req_ready;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] expired;
  logic              busy;
  logic              overrun;

  atm_timer_scheduler #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk_in    (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ch    (req_ch),
    .req_ticks (req_ticks),
    .req_ready (req_ready),
    .active    (active),
    .expired   (expired),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: every accepted tick books a sweep window [base, base+NUM_CH). The
  // window's outcome is computed at once, since no command can land while sweeps chain.
  typedef struct {
    int t;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  cyc       = 0;
  bit  started   = 0;
  int  last_base = -1000;
  int  prev_base = -1000;
  int  rem[NUM_CH];
  bit  act[NUM_CH];
  bit  m_ovr     = 0;

  function automatic bit model_busy(int c);
    return (c >= last_base && c < last_base + NUM_CH) ||
           (c >= prev_base && c < prev_base + NUM_CH);
  endfunction

  task automatic run_sweep(int b);
    prev_base = last_base;
    last_base = b;
    for (int k = 0; k < NUM_CH; k++) begin
      if (act[k]) begin
        if (rem[k] > 1) begin
          rem[k]--;
        end else begin
          rem[k] = 0;
          act[k] = 0;
          exp_q.push_back('{t: b + k + 1, ch: k});
        end
      end
    end
  endtask

  always @(posedge clk) begin : model
    int c;
    int ch;
    c = cyc;
    if (reset) begin
      started = 1;
      exp_q.delete();
      for (int k = 0; k < NUM_CH; k++) begin
        rem[k] = 0;
        act[k] = 0;
      end
      last_base = -1000;
      prev_base = -1000;
      m_ovr = 0;
    end else if (started) begin
      if (tick_in) begin
        if (c >= last_base + NUM_CH) run_sweep(c + 1);         // idle: start right away
        else if (c < last_base) m_ovr = 1;                     // one already queued: drop
        else run_sweep(last_base + NUM_CH);                    // queue behind current
      end else if (req_valid && c >= last_base + NUM_CH) begin
        ch = int'(req_ch);
        if (req_cmd == 1'b0 && req_ticks != 0) begin
          act[ch] = 1;
          rem[ch] = int'(req_ticks);
        end else begin
          act[ch] = 0;
          rem[ch] = 0;
          if (req_cmd == 1'b0) exp_q.push_back('{t: c + 1, ch: ch});
        end
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] act_v;
    bit bz;
    if (started && !reset) begin
      ev = '0;
      while (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        ev[exp_q[0].ch] = 1'b1;
        void'(exp_q.pop_front());
      end
      for (int k = 0; k < NUM_CH; k++) act_v[k] = act[k];
      bz = model_busy(cyc);
      check("busy", int'(busy), int'(bz));
      check("req_ready", int'(req_ready), int'(!tick_in && !bz));
      check("expired", int'(expired), int'(ev));
      if (!bz) check("active", int'(active), int'(act_v));
`ifdef ATM_TIMER_OVERRUN_EN
      check("overrun", int'(overrun), int'(m_ovr));
`else
      check("overrun", int'(overrun), 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    tick_in = 1'b0;
  endtask

  task automatic tick_then(int gap);
    tick_in = 1'b1;
    step();
    repeat (gap) step();
  endtask

  task automatic send(input logic cmd, input int ch, input int ticks, output int acc);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_ch    = CH_W'(ch);
    req_ticks = CNT_W'(ticks);
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
      @(posedge clk);
      #1;
      tick_in = 1'b0;
      if (acc >= 0) break;
    end
    req_valid = 1'b0;
    check("req_accepted_in_time", int'(acc >= 0), 1);
  endtask

  initial begin
    int acc;
    int t;
    int r;
    repeat (3) step();
    reset = 1'b0;
    step();

    // START ch0 = 3, ticks every 50 cycles.
    send(1'b0, 0, 3, acc);
    repeat (4) tick_then(49);

    // Zero-length START on ch2.
    send(1'b0, 2, 0, acc);
    repeat (3) step();

    // START ch1 = 5, two ticks, cancel, then ten more ticks with no expiry.
    send(1'b0, 1, 5, acc);
    repeat (2) tick_then(20);
    send(1'b1, 1, 0, acc);
    repeat (10) tick_then(20);

    // Tick and command in the same idle cycle: tick wins.
    tick_in = 1'b1;
    t = cyc;
    send(1'b0, 0, 7, acc);
    check("tick_priority_accept_cycle", acc, t + 1 + NUM_CH);
    send(1'b1, 0, 0, acc);

    // All channels at 2, two ticks two cycles apart, third tick while one is pending.
    for (int k = 0; k < NUM_CH; k++) send(1'b0, k, 2, acc);
    tick_then(1);
    tick_then(0);
    tick_then(20);

    // Reset while ch3 (count 1) is being swept.
    send(1'b0, 3, 1, acc);
    tick_then(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 399));
      if (r == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else if (r < 25) begin
        tick_in = 1'b1;
        step();
      end else if (r < 140) begin
        if (r < 40) tick_in = 1'b1;
        send(($urandom_range(0, 3) == 0), int'($urandom_range(0, NUM_CH - 1)),
             int'($urandom_range(0, 4)), acc);
      end else begin
        step();
      end
    end

    repeat (30) step();
    check("expiry_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
